// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction-fetch stage: owns the PC, runs the imem handshake, feeds IF/ID
//
// Optional feature: define FETCH_PERF_EN to add the perf_fetched/perf_wait counters.
//
// Ports:
//   clk            in   core clock, all state updates on the rising edge
//   rst            in   synchronous active-high reset
//   stall          in   hazard stall, PC holds and the same word is refetched
//   redirect       in   taken branch/jump, flush and load redirect_pc
//   redirect_pc    in   [15:0] redirect target
//   imem_req       out  instruction-memory request (dropping it aborts)
//   imem_addr      out  [15:0] request address (= pc)
//   imem_rdy       in   imem_data valid this cycle for imem_addr
//   imem_data      in   [15:0] instruction word
//   fetch_valid    out  fetch_* outputs carry a real instruction
//   fetch_opc      out  [15:0] PC of the fetched instruction
//   fetch_pc_plus2 out  [15:0] pc+2 modulo 2^16
//   fetch_instr    out  [15:0] imem_data when fetch_valid, else NOP_INSTR
//   halted         out  stage is parked on an HLT
//   mem_timeout    out  sticky, a request waited more than MAX_WAIT cycles
//   perf_fetched   out  [15:0] (FETCH_PERF_EN) cycles with fetch_valid & ~stall
//   perf_wait      out  [15:0] (FETCH_PERF_EN) cycles spent in WAIT

module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000,
  parameter int unsigned MAX_WAIT  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  output logic        fetch_valid,
  output logic [15:0] fetch_opc,
  output logic [15:0] fetch_pc_plus2,
  output logic [15:0] fetch_instr,
  output logic        halted,
  output logic        mem_timeout
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] perf_fetched,
  output logic [15:0] perf_wait
`endif
);

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  logic [15:0] pc_q, pc_d;
  logic [1:0]  state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic        is_hlt;

  assign is_hlt = (imem_data[15:12] == 4'hF);

  assign imem_req       = (state_q != S_HALTED);
  assign imem_addr      = pc_q;
  assign fetch_opc      = pc_q;
  assign fetch_pc_plus2 = pc_q + 16'd2;
  assign fetch_valid    = imem_rdy & imem_req & ~redirect;
  assign fetch_instr    = fetch_valid ? imem_data : NOP_INSTR;
  assign halted         = (state_q == S_HALTED);
  assign mem_timeout    = mem_timeout_q;

  always_comb begin
    pc_d          = pc_q;
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;

    if (redirect) begin
      // Redirect also leaves HALTED: the HLT may have been on a squashed path.
      pc_d       = redirect_pc;
      state_d    = S_FETCH;
      wait_cnt_d = 8'd0;
    end else begin
      case (state_q)
        S_FETCH, S_WAIT: begin
          if (imem_rdy) begin
            wait_cnt_d = 8'd0;
            if (is_hlt) begin
              // HLT wins over stall; PC stays on the HLT address.
              state_d = S_HALTED;
            end else begin
              state_d = S_FETCH;
              if (!stall) begin
                pc_d = pc_q + 16'd2;
              end
            end
          end else if (state_q == S_FETCH) begin
            state_d    = S_WAIT;
            wait_cnt_d = 8'd1;
          end else begin
            if (wait_cnt_q != 8'hFF) begin
              wait_cnt_d = wait_cnt_q + 8'd1;
            end
            // Counter already at MAX_WAIT and still no data: the request has
            // now waited more than MAX_WAIT cycles.
            if (wait_cnt_q >= MAX_WAIT_C) begin
              mem_timeout_d = 1'b1;
            end
          end
        end
        S_HALTED: begin
          state_d = S_HALTED;
        end
        default: begin
          state_d    = S_FETCH;
          wait_cnt_d = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      state_q       <= S_FETCH;
      wait_cnt_q    <= 8'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched_q, perf_fetched_d;
  logic [15:0] perf_wait_q, perf_wait_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_wait_d    = perf_wait_q;
    if (fetch_valid && !stall) begin
      perf_fetched_d = perf_fetched_q + 16'd1;
    end
    if (state_q == S_WAIT) begin
      perf_wait_d = perf_wait_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= 16'd0;
      perf_wait_q    <= 16'd0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_wait_q    <= perf_wait_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_wait    = perf_wait_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with a behavioural reference model

module tb_fetch_stage;

  localparam logic [15:0] RESET_PC  = 16'h0000;
  localparam logic [15:0] NOP_INSTR = 16'h0000;
  localparam int          MAX_WAIT  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        imem_rdy = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        fetch_valid;
  logic [15:0] fetch_opc;
  logic [15:0] fetch_pc_plus2;
  logic [15:0] fetch_instr;
  logic        halted;
  logic        mem_timeout;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched;
  logic [15:0] perf_wait;
`endif

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP_INSTR),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdy      (imem_rdy),
    .imem_data     (imem_data),
    .fetch_valid   (fetch_valid),
    .fetch_opc     (fetch_opc),
    .fetch_pc_plus2(fetch_pc_plus2),
    .fetch_instr   (fetch_instr),
    .halted        (halted),
    .mem_timeout   (mem_timeout)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_wait     (perf_wait)
`endif
  );

  typedef struct {
    bit          check;
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic        hlt;
    logic        tmo;
  } stat_t;

  typedef struct {
    logic [15:0] opc;
    logic [15:0] instr;
  } fet_t;

  stat_t sq[$];
  fet_t  fq[$];

  int total = 0;
  int bad   = 0;

  // Reference model: architectural PC, halted flag, length of the current
  // unanswered request, sticky timeout.
  logic [15:0] m_pc     = 16'h0000;
  bit          m_halted = 1'b0;
  int          m_miss   = 0;
  bit          m_tmo    = 1'b0;
  bit          m_known  = 1'b0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit rd, input logic [15:0] rp,
                     input bit st, input bit ry, input logic [15:0] d);
    stat_t s;
    fet_t  f;
    rst         = r;
    redirect    = rd;
    redirect_pc = rp;
    stall       = st;
    imem_rdy    = ry;
    imem_data   = d;

    s.check = m_known;
    s.req   = !m_halted;
    s.addr  = m_pc;
    s.valid = ry && !m_halted && !rd;
    s.hlt   = m_halted;
    s.tmo   = m_tmo;
    sq.push_back(s);
    if (m_known && s.valid) begin
      f.opc   = m_pc;
      f.instr = d;
      fq.push_back(f);
    end

    if (r) begin
      m_pc = RESET_PC; m_halted = 1'b0; m_miss = 0; m_tmo = 1'b0; m_known = 1'b1;
    end else if (rd) begin
      m_pc = rp; m_halted = 1'b0; m_miss = 0;
    end else if (!m_halted) begin
      if (ry) begin
        m_miss = 0;
        if (d[15:12] == 4'hF) m_halted = 1'b1;
        else if (!st) m_pc = m_pc + 16'd2;
      end else begin
        m_miss++;
        if (m_miss > MAX_WAIT) m_tmo = 1'b1;
      end
    end

    @(posedge clk);
    #1;
  endtask

  stat_t ms;
  fet_t  mf;

  always @(negedge clk) begin
    if (sq.size() > 0) begin
      ms = sq.pop_front();
      if (ms.check) begin
        chk("imem_req",    16'(imem_req),    16'(ms.req));
        chk("imem_addr",   imem_addr,        ms.addr);
        chk("halted",      16'(halted),      16'(ms.hlt));
        chk("mem_timeout", 16'(mem_timeout), 16'(ms.tmo));
        chk("fetch_valid", 16'(fetch_valid), 16'(ms.valid));
        if (fetch_valid === 1'b1) begin
          if (fq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL fetch_queue actual=unexpected_fetch_at_%h required=no_fetch", fetch_opc);
          end else begin
            mf = fq.pop_front();
            chk("fetch_opc",      fetch_opc,      mf.opc);
            chk("fetch_pc_plus2", fetch_pc_plus2, mf.opc + 16'd2);
            chk("fetch_instr",    fetch_instr,    mf.instr);
          end
        end else begin
          chk("fetch_instr_nop", fetch_instr, NOP_INSTR);
        end
      end
    end
  end

  int          low_left;
  bit          r_r, r_rd, r_st, r_ry;
  logic [15:0] r_rp, r_d;

  initial begin
    @(posedge clk);
    #1;
    cyc(1, 0, 16'h0000, 0, 0, 16'h0000);
    cyc(1, 0, 16'h0000, 0, 0, 16'h0000);

    // Back-to-back fetches from reset.
    cyc(0, 0, 16'h0000, 0, 1, 16'h1234);
    cyc(0, 0, 16'h0000, 0, 1, 16'h5678);

    // Three-cycle miss at 0x0010.
    cyc(0, 1, 16'h0010, 0, 0, 16'h0000);
    for (int i = 0; i < 3; i++) cyc(0, 0, 16'h0000, 0, 0, 16'h0000);
    cyc(0, 0, 16'h0000, 0, 1, 16'h1111);

    // Two-cycle stall at 0x0020.
    cyc(0, 1, 16'h0020, 0, 0, 16'h0000);
    cyc(0, 0, 16'h0000, 1, 1, 16'h2020);
    cyc(0, 0, 16'h0000, 1, 1, 16'h2020);
    cyc(0, 0, 16'h0000, 0, 1, 16'h2020);
    cyc(0, 0, 16'h0000, 0, 1, 16'h2022);

    // Redirect to 0x0100 during a WAIT at 0x0040.
    cyc(0, 1, 16'h0040, 0, 0, 16'h0000);
    cyc(0, 0, 16'h0000, 0, 0, 16'h0000);
    cyc(0, 1, 16'h0100, 0, 1, 16'h4040);
    cyc(0, 0, 16'h0000, 0, 1, 16'h0101);

    // HLT at 0x0030 (with stall asserted), then redirect out to 0x0008.
    cyc(0, 1, 16'h0030, 0, 0, 16'h0000);
    cyc(0, 0, 16'h0000, 1, 1, 16'hF000);
    for (int i = 0; i < 3; i++) cyc(0, 0, 16'h0000, 0, 1, 16'h3333);
    cyc(0, 1, 16'h0008, 0, 0, 16'h0000);
    cyc(0, 0, 16'h0000, 0, 1, 16'h2222);

    // PC wrap at the top of the address space.
    cyc(0, 1, 16'hFFFE, 0, 0, 16'h0000);
    cyc(0, 0, 16'h0000, 0, 1, 16'h7777);
    cyc(0, 0, 16'h0000, 0, 1, 16'h8888);

    // Nine-cycle miss: timeout sets, stays after data, clears on reset.
    cyc(0, 1, 16'h0050, 0, 0, 16'h0000);
    for (int i = 0; i < 9; i++) cyc(0, 0, 16'h0000, 0, 0, 16'h0000);
    cyc(0, 0, 16'h0000, 0, 1, 16'h5050);
    cyc(0, 0, 16'h0000, 0, 1, 16'h5052);
    cyc(1, 0, 16'h0000, 0, 0, 16'h0000);
    cyc(0, 0, 16'h0000, 0, 1, 16'h0001);

    // Randomized traffic with bursty memory latency.
    low_left = 0;
    for (int i = 0; i < 3000; i++) begin
      r_r  = ($urandom_range(0, 99) == 0);
      r_rd = ($urandom_range(0, 9) == 0);
      r_rp = 16'($urandom) & 16'hFFFE;
      r_st = ($urandom_range(0, 3) == 0);
      if (low_left > 0) begin
        r_ry = 1'b0;
        low_left--;
      end else if ($urandom_range(0, 7) == 0) begin
        low_left = $urandom_range(0, 11);
        r_ry = 1'b0;
      end else begin
        r_ry = 1'b1;
      end
      r_d = 16'($urandom);
      cyc(r_r, r_rd, r_rp, r_st, r_ry, r_d);
    end

    @(negedge clk);
    #1;
    total++;
    if (fq.size() != 0) begin
      bad++;
      $display("FAIL fetch_queue_drain actual=%0d required=0", fq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
